// File: rtl/uart_tx.sv
// UART transmitter driven by a 16x oversample tick: start bit, N_BITS data LSB first, optional parity, stop.
// All outputs come straight from flops, so tx never sees a combinational path from the inputs.
module uart_tx #(
  parameter int N_BITS  = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              tx_start,
  input  logic [N_BITS-1:0] din,
  output logic              tx_busy,
  output logic              tx_done_tick,
  output logic              tx
);

  // The tick counter widens only when the stop period needs more than 16 ticks.
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(N_BITS - 1);

  // state | meaning: IDLE line high | START 16 ticks low | DATA lsb first | PAR parity bit | STOP SB_TICK ticks high
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t            state_q;
  logic [S_W-1:0]    s_q;
  logic [N_W-1:0]    n_q;
  logic [N_BITS-1:0] sh_q;
  logic              par_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            sh_q    <= din;
            // The shift register is consumed during DATA, so parity is fixed at acceptance.
            par_q   <= (PARITY == 2) ? ~(^din) : (^din);
            s_q     <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= sh_q[0];
              state_q <= DATA;
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q  <= '0;
              sh_q <= {1'b0, sh_q[N_BITS-1:1]};
              if (n_q == N_LAST) begin
                if (PARITY != 0) begin
                  tx_q    <= par_q;
                  state_q <= PAR;
                end else begin
                  tx_q    <= 1'b1;
                  state_q <= STOP;
                end
              end else begin
                n_q  <= n_q + N_W'(1);
                tx_q <= sh_q[1];
              end
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        PAR: begin
          if (s_tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (s_tick) begin
            if (s_q == S_STOP_LAST) begin
              s_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              s_q <= s_q + S_W'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop bits) share stimulus;
// a bench-side mid-bit sampler recovers each frame and compares it with hand-computed bit patterns.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] tx_w, busy_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_div = 1;
  int tick_cnt = 0;

  logic [10:0] slots [4];
  int          done_cnt [4] = '{0, 0, 0, 0};
  int          busy_cnt [4] = '{0, 0, 0, 0};
  logic [3:0]  busy_prev = 4'h0;
  int          order_err = 0;
  int          done_snap [4];
  int          busy_snap [4];
  logic [7:0]  words [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};

  uart_tx #(.N_BITS(8), .SB_TICK(16), .PARITY(0)) u_none (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]), .tx(tx_w[0]));
  uart_tx #(.N_BITS(8), .SB_TICK(16), .PARITY(1)) u_even (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]), .tx(tx_w[1]));
  uart_tx #(.N_BITS(8), .SB_TICK(16), .PARITY(2)) u_odd (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]), .tx(tx_w[2]));
  uart_tx #(.N_BITS(8), .SB_TICK(32), .PARITY(0)) u_sb32 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]), .tx(tx_w[3]));

  always #5 clk = ~clk;

  // Tick source: one-clk pulse every tick_div clocks (tick_div = 1 means tied high).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt + 1 >= tick_div) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == 0);
    end
  end

  // Done must be a single cycle right after busy drops.
  always @(negedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (busy_w[j]) busy_cnt[j]++;
      if (done_w[j]) begin
        done_cnt[j]++;
        if (busy_w[j] || !busy_prev[j]) order_err++;
      end
    end
    busy_prev = busy_w;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (s_tick) c++;
    end
  endtask

  task automatic snap();
    for (int j = 0; j < 4; j++) begin
      done_snap[j] = done_cnt[j];
      busy_snap[j] = busy_cnt[j];
    end
  endtask

  // Waits for the start edge on u_none's line, then samples all four lines mid-bit.
  task automatic rx_frame(input int nslots);
    logic prev = 1'b1;
    int   t = 0;
    for (int j = 0; j < 4; j++) slots[j] = '1;
    forever begin
      @(negedge clk);
      if (prev && !tx_w[0]) break;
      prev = tx_w[0];
      t++;
      if (t > 4000) begin
        chk("rx_timeout", 32'(t), 32'd0);
        return;
      end
    end
    wait_ticks(8);
    for (int j = 0; j < 4; j++) slots[j][0] = tx_w[j];
    for (int s = 1; s < nslots; s++) begin
      wait_ticks(16);
      for (int j = 0; j < 4; j++) slots[j][s] = tx_w[j];
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    din      = d;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    tx_start = 1'b0;
    din      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",   32'(tx_w),   32'hF);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_done", 32'(done_w), 32'h0);
    @(negedge clk) reset = 1'b0;

    // A5 with a slow tick (64 clks per bit): slot i is line value mid bit i.
    tick_div = 4;
    repeat (8) @(negedge clk);
    snap();
    start_frame(8'hA5);
    rx_frame(11);
    chk("a5_none", 32'(slots[0]), 32'(11'b11101001010));
    chk("a5_even", 32'(slots[1]), 32'(11'b10101001010));
    chk("a5_odd",  32'(slots[2]), 32'(11'b11101001010));
    chk("a5_sb32", 32'(slots[3]), 32'(11'b11101001010));
    repeat (300) @(negedge clk);
    for (int j = 0; j < 4; j++) chk("a5_done_cnt", 32'(done_cnt[j] - done_snap[j]), 32'd1);

    // 07 with tick tied high: exact frame lengths in clocks.
    tick_div = 1;
    repeat (4) @(negedge clk);
    snap();
    start_frame(8'h07);
    rx_frame(11);
    repeat (30) @(negedge clk);
    chk("x07_none", 32'(slots[0]), 32'(11'b11000001110));
    chk("x07_even", 32'(slots[1]), 32'(11'b11000001110));
    chk("x07_odd",  32'(slots[2]), 32'(11'b10000001110));
    chk("busy_len_none", 32'(busy_cnt[0] - busy_snap[0]), 32'd160);
    chk("busy_len_even", 32'(busy_cnt[1] - busy_snap[1]), 32'd176);
    chk("busy_len_sb32", 32'(busy_cnt[3] - busy_snap[3]), 32'd176);
    chk("x07_done_cnt", 32'(done_cnt[3] - done_snap[3]), 32'd1);

    // Second request mid-DATA must be ignored.
    snap();
    fork
      begin
        start_frame(8'hA5);
        repeat (60) @(posedge clk);
        #1;
        din      = 8'h3C;
        tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
      end
      rx_frame(11);
    join
    repeat (30) @(negedge clk);
    chk("ign_none", 32'(slots[0]), 32'(11'b11101001010));
    chk("ign_sb32", 32'(slots[3]), 32'(11'b11101001010));
    chk("ign_done_none", 32'(done_cnt[0] - done_snap[0]), 32'd1);
    chk("ign_done_sb32", 32'(done_cnt[3] - done_snap[3]), 32'd1);

    // Reset during data bit 4 (clks 80..95 after acceptance; A5 bit 4 is 0).
    start_frame(8'hA5);
    repeat (87) @(posedge clk);
    #2;
    chk("pre_rst_tx",   32'(tx_w[0]),   32'd0);
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_tx",   32'(tx_w),   32'hF);
    chk("mid_rst_busy", 32'(busy_w), 32'h0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    snap();
    start_frame(8'h81);
    rx_frame(11);
    repeat (30) @(negedge clk);
    chk("post_rst_none", 32'(slots[0]), 32'(11'b11100000010));
    chk("post_rst_sb32", 32'(slots[3]), 32'(11'b11100000010));
    chk("post_rst_done", 32'(done_cnt[0] - done_snap[0]), 32'd1);

    // Back-to-back with tx_start held high; din advances after each acceptance.
    snap();
    fork
      begin
        logic bp;
        int   t;
        @(negedge clk);
        din      = words[0];
        tx_start = 1'b1;
        bp       = busy_w[0];
        for (int k = 0; k < 4; k++) begin
          t = 0;
          forever begin
            @(negedge clk);
            if (!bp && busy_w[0]) break;
            bp = busy_w[0];
            t++;
            if (t > 2000) break;
          end
          bp = busy_w[0];
          if (t > 2000) begin
            chk("b2b_timeout", 32'(t), 32'd0);
            break;
          end
          if (k < 3) din = words[k + 1];
          else tx_start = 1'b0;
        end
        tx_start = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          rx_frame(10);
          chk("b2b_data", 32'(slots[0][8:1]), 32'(words[k]));
          chk("b2b_stop", 32'(slots[0][9]), 32'd1);
        end
      end
    join
    repeat (400) @(negedge clk);
    chk("b2b_done_cnt", 32'(done_cnt[0] - done_snap[0]), 32'd4);
    chk("done_order", 32'(order_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
